// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with registered one-hot grant.
// Define RR_ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles under contention.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] cur;
  logic [1:0] nxt;
  logic [1:0] sel_ptr;
  logic [1:0] sel_nxt;
  logic [3:0] others;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD = CW'(MAX_HOLD);
  logic [CW-1:0] cnt;
`endif

  function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] start);
    logic [1:0] r;
    logic [1:0] idx;
    r = start;
    // Scan farthest offset first so the nearest set bit overwrites and wins.
    for (int unsigned k = 0; k < 4; k++) begin
      idx = start + 2'(3 - k);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  always_comb begin
    nxt     = cur + 2'd1;
    others  = req & ~(4'b0001 << cur);
    sel_ptr = pick(req, ptr);
    sel_nxt = pick(others, nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en && (|req)) begin
            state     <= BUSY;
            cur       <= sel_ptr;
            gnt       <= 4'b0001 << sel_ptr;
            gnt_id    <= sel_ptr;
            gnt_valid <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            cnt       <= CW'(1);
`endif
          end
        end
        BUSY: begin
          if (!en) begin
            state     <= IDLE;
            ptr       <= nxt;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
          end else if (!req[cur]) begin
            ptr <= nxt;
            // Hand over directly when anyone else waits, avoiding an idle bubble.
            if (|others) begin
              cur       <= sel_nxt;
              gnt       <= 4'b0001 << sel_nxt;
              gnt_id    <= sel_nxt;
`ifdef RR_ARB_TIMEOUT_EN
              cnt       <= CW'(1);
`endif
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_id    <= '0;
              gnt_valid <= 1'b0;
            end
          end
`ifdef RR_ARB_TIMEOUT_EN
          else if ((cnt == HOLD) && (|others)) begin
            ptr    <= nxt;
            cur    <= sel_nxt;
            gnt    <= 4'b0001 << sel_nxt;
            gnt_id <= sel_nxt;
            cnt    <= CW'(1);
          end else if (cnt != HOLD) begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt) && (gnt_valid == (|gnt)));
  a_hold_legal: assert property (@(posedge clk) MAX_HOLD >= 1);

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter. It shares one downstream resource, such as the 4-to-2 encoded select path, among requesters `req[3:0]`. It issues a registered one-hot grant, the matching 2-bit encoded grant index and a valid flag. Fairness comes from a rotating priority pointer, and an optional hold limit forces rotation when a requester monopolises the resource.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one requester keeps the grant while others wait. Legal range ≥1. Used only with `RR_ARB_TIMEOUT_EN`.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  arbiter enable; 0 forces release and blocks new grants.
- `req`  in  4  request lines, bit i = requester i; level-sensitive.
- `gnt`  out  4  one-hot grant, registered; all-zero when nothing granted.
- `gnt_id`  out  2  binary index of the granted bit (0..3); 0 when `gnt_valid`=0.
- `gnt_valid`  out  1  high iff `gnt` is non-zero.

## Operation
- State: FSM {IDLE, BUSY}; `ptr[1:0]` = highest-priority index; `cur[1:0]` = current grantee; `cnt` = hold counter, width $clog2(MAX_HOLD+1).
- Selection function: first set bit of a request mask, searching cyclically from a start index, i.e. start, start+1, … mod 4.
- IDLE:
  - If `en` and `|req`: select from `req` starting at `ptr`, go to BUSY, `cnt`←1.
  - Otherwise stay in IDLE with outputs zero.
- BUSY, with priority in this order:
  1. `en`=0: go to IDLE, `ptr`←`cur`+1.
  2. `req[cur]`=0: release, `ptr`←`cur`+1.
     - If other requests are pending, grant the next requester in the same cycle (no idle bubble), searching from `cur`+1, and set `cnt`←1.
     - Otherwise go to IDLE.
  3. Timeout enabled, `cnt`==MAX_HOLD and `req & ~(1<<cur)` non-zero: forced rotation to the next requester searching from `cur`+1; `ptr`←`cur`+1; `cnt`←1.
  4. Otherwise hold the grant; `cnt` increments, saturating at MAX_HOLD.
- `ptr` wraps 3→0; `cur`+1 is computed modulo 4.
- Encoding: `gnt_id` is the binary of the one-hot `gnt`, so `gnt`=0001/0010/0100/1000 maps to `gnt_id`=00/01/10/11.
- Requests that appear or drop in the same cycle as a grant decision are sampled as seen at that edge. No request latching.

## Timing
- Reset (asynchronous, immediate): `gnt`=0000, `gnt_id`=00, `gnt_valid`=0, state IDLE, `ptr`=0, `cnt`=0. Asserting reset mid-grant clears the outputs without waiting for a clock edge.
- Latency: `req` sampled at edge N → `gnt` visible after edge N (1 cycle).
- Release: `req[cur]` low at edge N → new grant or zero after edge N. A handover never produces a zero cycle.
- With `MAX_HOLD`=M and contention, a grantee holds exactly M cycles, then rotates.
- At most one `gnt` bit high in any cycle. The outputs are glitch-free because they come straight from registers.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined: the BUSY step 3 forced rotation is active and `MAX_HOLD` is honoured.
- Not defined: step 3 is omitted and `cnt` is not implemented. A grantee keeps the grant until `req[cur]` drops or `en`=0. This is pure release-based round-robin.

## Test plan
- Reset then single request: `rst` pulse; `en`=1, `req`=0100 → next cycle `gnt`=0100, `gnt_id`=10, `gnt_valid`=1. Assert `rst` mid-grant → outputs 0 immediately.
- Rotation fairness: `en`=1, `req`=1111, each grantee drops its request one cycle after being granted and re-raises it next cycle → grants 0001, 0010, 0100, 1000, 0001 with no zero cycles between them.
- Wrap and pointer: grant 1000 and release it, then `req`=1001 → `gnt`=0001, because `ptr` has wrapped to 0.
- Timeout (macro defined, `MAX_HOLD`=4): `req`=0011 held constant → `gnt`=0001 for 4 cycles, then 0010 for 4 cycles, then 0001. Without the macro, `gnt`=0001 holds indefinitely.
- Enable: during a grant of 0010, set `en`=0 → next cycle `gnt`=0000, `gnt_id`=00, `gnt_valid`=0. Set `en`=1 with `req`=0010 → `gnt` becomes 0010 again, because `ptr`=2 and no one else is requesting.
- Idle: `en`=1, `req`=0000 for 5 cycles → `gnt_valid` stays 0 throughout.
